xpu_vpu_pc_com_root_gated_clk_ctrl: RTL and testbench
=====================================================

XPU_VPU_PC_COM_ROOT_GATED_CLK_CTRL -- requirements
Module: xpu_vpu_pc_com_root_gated_clk_ctrl

Interface
REQ-001 The block SHALL have parameter CH_NUM, default 4: number of independently gated clock channels, legal range 1..16.
REQ-002 The block SHALL have parameter HOLD_W, default 4: width of the hold-off counter and the hold_cfg input, legal range 1..8.
REQ-003 The block SHALL have one clock and one reset: a single clock domain clk_in, and reset cpurst_b, which is asynchronous and active-low.
REQ-004 Port clk_in SHALL be an input, 1 bit: the free-running root clock.
REQ-005 Port cpurst_b SHALL be an input, 1 bit: asynchronous active-low reset.
REQ-006 Port module_en SHALL be an input, 1 bit: global enable that requests all channels.
REQ-007 Port local_en SHALL be an input, CH_NUM bits: per-channel local enable.
REQ-008 Port external_en SHALL be an input, CH_NUM bits: per-channel external enable.
REQ-009 Port pad_yy_icg_scan_en SHALL be an input, 1 bit: scan enable, which forces every ICG transparent.
REQ-010 Port hold_cfg SHALL be an input, HOLD_W bits: the number of hold-off cycles after the request drops.
REQ-011 Port clk_out SHALL be an output, CH_NUM bits: the gated clock for each channel.
REQ-012 Port ch_rdy SHALL be an output, CH_NUM bits: per channel, the gated clock has been running for at least one full cycle.
REQ-013 Port all_idle SHALL be an output, 1 bit: every channel is in OFF.

Function
REQ-014 For each channel i, req[i] SHALL be module_en | local_en[i] | external_en[i], evaluated combinationally each cycle.
REQ-015 Each channel SHALL contain an independent three-state FSM with states OFF, ON and HOLD, clocked by clk_in.
REQ-016 OFF SHALL go to ON when req[i]=1, and otherwise remain in OFF.
REQ-017 ON SHALL go to HOLD when req[i]=0 and hold_cfg!=0, loading cnt[i]=hold_cfg; ON SHALL go directly to OFF when req[i]=0 and hold_cfg=0; ON SHALL otherwise remain in ON.
REQ-018 HOLD SHALL go to ON when req[i]=1, with cnt[i] cleared to 0; HOLD SHALL go to OFF when req[i]=0 and cnt[i]=1; HOLD SHALL otherwise decrement cnt[i] by 1 and remain in HOLD.
REQ-019 hold_cfg SHALL be sampled only on the ON->HOLD transition; changes to hold_cfg during HOLD SHALL NOT affect the counter in progress.
REQ-020 gate_en[i] SHALL be registered, and SHALL equal 1 whenever the channel state is ON or HOLD, so the clock opens one clk_in cycle after req rises.
REQ-021 Each channel SHALL instantiate one CKLNQD8BWP6T16P96CPDLVT cell with CP=clk_in, E=gate_en[i], TE=pad_yy_icg_scan_en and Q=clk_out[i].
REQ-022 No combinational logic SHALL sit on the clk_in to clk_out path other than the ICG cell.
REQ-023 ch_rdy[i] SHALL be a registered signal equal to gate_en[i] delayed by one cycle AND gate_en[i]: it rises 2 cycles after req rises and falls in the same cycle gate_en falls.
REQ-024 all_idle SHALL be registered, and SHALL be 1 exactly when every channel state was OFF in the previous cycle.
REQ-025 In scan mode (pad_yy_icg_scan_en=1), the clocks SHALL run regardless of the FSMs, and the FSM, ch_rdy and all_idle SHALL be unaffected by scan mode.
REQ-026 When module_en and a per-channel enable toggle in the same cycle, the OR in REQ-014 SHALL decide the outcome, with no priority between them.
REQ-027 The hold counter SHALL never wrap: the maximum hold is 2^HOLD_W-1 cycles and decrement below 1 SHALL NOT occur.

Reset
REQ-028 Asserting cpurst_b=0 SHALL immediately force every FSM to OFF, and SHALL set cnt=0, gate_en=0, ch_rdy=0 and all_idle=1.
REQ-029 With gate_en=0 under reset, clk_out SHALL be low unless pad_yy_icg_scan_en=1.
REQ-030 Reset asserted mid-HOLD or mid-ON SHALL close the clock within the current low phase, because the ICG latches E only while CP is low.
REQ-031 Reset deassertion SHALL be synchronised externally, and the first FSM transition SHALL occur on the first clk_in edge after release.

Verification
REQ-032 Wake: CH_NUM=4; drive local_en[2]=1 at cycle 0 -> gate_en[2]=1 at cycle 1, clk_out[2] toggles from cycle 1, ch_rdy[2]=1 at cycle 2, all_idle=0 at cycle 2, and channels 0, 1 and 3 stay gated.
REQ-033 Hold-off: hold_cfg=3 with local_en[0] dropped at cycle 10 -> HOLD during cycles 11..13, OFF at cycle 14, clk_out[0] stops after cycle 13, ch_rdy[0]=0 at cycle 14.
REQ-034 Re-request during HOLD: hold_cfg=5, req drops, then rises after 2 cycles -> back to ON with no clock gap; a later drop reloads cnt=5.
REQ-035 Zero hold and global enable: hold_cfg=0 and req pulsed for 1 cycle -> ON then OFF with exactly 1 gated edge; module_en=1 -> all 4 channels wake simultaneously.
REQ-036 Scan and reset: pad_yy_icg_scan_en=1 with all enables 0 -> all clk_out toggle while all_idle stays 1; cpurst_b pulsed low mid-HOLD -> clock stops, all outputs take their reset values, and no glitch appears on clk_out (checked with a glitch/pulse-width assertion).

Source files
------------

// File: rtl/xpu_vpu_pc_com_root_gated_clk_ctrl.sv
// Root clock-gating controller for the VPU PC complex.
// Each channel runs an OFF/ON/HOLD state machine that keeps its gated clock
// open while requested, plus a programmable hold-off after the request drops.
// The gated clock leaves through a single ICG cell per channel, so no logic
// other than the cell sits between clk_in and clk_out.

module xpu_vpu_pc_com_root_gated_clk_ctrl #(
  parameter int CH_NUM = 4,
  parameter int HOLD_W = 4
) (
  input  logic              clk_in,
  input  logic              cpurst_b,
  input  logic              module_en,
  input  logic [CH_NUM-1:0] local_en,
  input  logic [CH_NUM-1:0] external_en,
  input  logic              pad_yy_icg_scan_en,
  input  logic [HOLD_W-1:0] hold_cfg,
  output logic [CH_NUM-1:0] clk_out,
  output logic [CH_NUM-1:0] ch_rdy,
  output logic              all_idle
);

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    ON   = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t              state     [CH_NUM];
  state_t              state_nxt [CH_NUM];
  logic [HOLD_W-1:0]   cnt       [CH_NUM];
  logic [HOLD_W-1:0]   cnt_nxt   [CH_NUM];
  logic [CH_NUM-1:0]   req;
  logic [CH_NUM-1:0]   gate_en;
  logic [CH_NUM-1:0]   gate_nxt;
  logic                all_off;

  // Global enable and both per-channel enables carry equal weight.
  assign req = {CH_NUM{module_en}} | local_en | external_en;

  // Next-state and hold counter for every channel; the counter never drops
  // below 1 while in HOLD, so it cannot wrap.
  always_comb begin
    all_off = 1'b1;
    for (int i = 0; i < CH_NUM; i++) begin
      state_nxt[i] = state[i];
      cnt_nxt[i]   = cnt[i];
      case (state[i])
        OFF: begin
          if (req[i]) state_nxt[i] = ON;
        end
        ON: begin
          if (!req[i]) begin
            if (hold_cfg != '0) begin
              state_nxt[i] = HOLD;
              cnt_nxt[i]   = hold_cfg;
            end else begin
              state_nxt[i] = OFF;
            end
          end
        end
        HOLD: begin
          if (req[i]) begin
            state_nxt[i] = ON;
            cnt_nxt[i]   = '0;
          end else if (cnt[i] <= HOLD_W'(1)) begin
            state_nxt[i] = OFF;
            cnt_nxt[i]   = '0;
          end else begin
            cnt_nxt[i]   = cnt[i] - HOLD_W'(1);
          end
        end
        default: begin
          state_nxt[i] = OFF;
          cnt_nxt[i]   = '0;
        end
      endcase
      gate_nxt[i] = (state_nxt[i] != OFF);
      if (state[i] != OFF) all_off = 1'b0;
    end
  end

  // State, counter and all registered status outputs; reset closes every gate.
  always_ff @(posedge clk_in or negedge cpurst_b) begin
    if (!cpurst_b) begin
      for (int i = 0; i < CH_NUM; i++) begin
        state[i] <= OFF;
        cnt[i]   <= '0;
      end
      gate_en  <= '0;
      ch_rdy   <= '0;
      all_idle <= 1'b1;
    end else begin
      for (int i = 0; i < CH_NUM; i++) begin
        state[i] <= state_nxt[i];
        cnt[i]   <= cnt_nxt[i];
      end
      gate_en  <= gate_nxt;
      // Ready only once the gate has already been open for a full cycle.
      ch_rdy   <= gate_en & gate_nxt;
      all_idle <= all_off;
    end
  end

  for (genvar g = 0; g < CH_NUM; g++) begin : g_icg
    CKLNQD8BWP6T16P96CPDLVT u_icg (
      .CP (clk_in),
      .E  (gate_en[g]),
      .TE (pad_yy_icg_scan_en),
      .Q  (clk_out[g])
    );
  end

endmodule

// Behavioural model of the library latch-based ICG: enable is captured only
// while CP is low, so a change on E or TE never truncates a high pulse.
module CKLNQD8BWP6T16P96CPDLVT (
  input  logic CP,
  input  logic E,
  input  logic TE,
  output logic Q
);

  logic en_lat;

  // Transparent-low enable latch.
  always_latch begin
    if (!CP) en_lat = E | TE;
  end

  assign Q = CP & en_lat;

endmodule

// File: tb/tb_xpu_vpu_pc_com_root_gated_clk_ctrl.sv
// Bench for the root gated clock controller: directed vectors push expected
// outputs tagged with a cycle number; a monitor pops and compares them.
`timescale 1ns/1ps

module tb_xpu_vpu_pc_com_root_gated_clk_ctrl;

  localparam int CH_NUM = 4;
  localparam int HOLD_W = 4;
  localparam int HALF   = 5;

  localparam int K_CLK    = 0;
  localparam int K_RDY    = 1;
  localparam int K_IDLE   = 2;
  localparam int K_GLITCH = 3;

  logic              clk_in = 1'b0;
  logic              cpurst_b = 1'b0;
  logic              module_en = 1'b0;
  logic [CH_NUM-1:0] local_en = '0;
  logic [CH_NUM-1:0] external_en = '0;
  logic              scan_en = 1'b0;
  logic [HOLD_W-1:0] hold_cfg = 4'd3;
  logic [CH_NUM-1:0] clk_out;
  logic [CH_NUM-1:0] ch_rdy;
  logic              all_idle;

  xpu_vpu_pc_com_root_gated_clk_ctrl #(.CH_NUM(CH_NUM), .HOLD_W(HOLD_W)) dut (
    .clk_in             (clk_in),
    .cpurst_b           (cpurst_b),
    .module_en          (module_en),
    .local_en           (local_en),
    .external_en        (external_en),
    .pad_yy_icg_scan_en (scan_en),
    .hold_cfg           (hold_cfg),
    .clk_out            (clk_out),
    .ch_rdy             (ch_rdy),
    .all_idle           (all_idle)
  );

  initial forever #HALF clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    int          kind;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   nvec  = 0;
  int   nfail = 0;

  // Pulse-width watcher: every high pulse on a gated clock must be a full half period.
  int              g_bad = 0;
  logic [CH_NUM-1:0] prev_clk = '0;
  time             rise_t [CH_NUM];
  always @(clk_out) begin
    for (int i = 0; i < CH_NUM; i++) begin
      if (clk_out[i] && !prev_clk[i]) begin
        rise_t[i] = $time;
      end else if (!clk_out[i] && prev_clk[i]) begin
        if (($time - rise_t[i]) != HALF) g_bad++;
      end
    end
    prev_clk = clk_out;
  end

  task automatic exp_at(input int c, input int kind, input logic [31:0] v, input string nm);
    exp_t e;
    int   idx;
    e.cyc  = c;
    e.kind = kind;
    e.val  = v;
    e.name = nm;
    idx = sb.size();
    while (idx > 0 && sb[idx-1].cyc > c) idx--;
    sb.insert(idx, e);
  endtask

  // Monitor: sample outputs mid high-phase and compare against due entries.
  always @(posedge clk_in) begin : mon
    exp_t        e;
    logic [31:0] act;
    #2;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      case (e.kind)
        K_CLK:   act = {28'd0, clk_out};
        K_RDY:   act = {28'd0, ch_rdy};
        K_IDLE:  act = {31'd0, all_idle};
        default: act = 32'(g_bad);
      endcase
      nvec++;
      if (e.cyc != cyc || act !== e.val) begin
        nfail++;
        $display("FAIL %s @cycle %0d (due %0d): got %0h expected %0h", e.name, cyc, e.cyc, act, e.val);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int b;
    tick(2);
    // Reset state
    exp_at(cyc, K_RDY,  0, "rst_rdy");
    exp_at(cyc, K_IDLE, 1, "rst_idle");
    exp_at(cyc, K_CLK,  0, "rst_clk");
    tick(1);
    cpurst_b = 1'b1;
    tick(2);

    // Wake channel 2, then hold-off of 3
    b = cyc;
    local_en = 4'b0100;
    exp_at(b+1, K_CLK, 0, "wake_clk1");   exp_at(b+1, K_RDY, 0, "wake_rdy1");
    exp_at(b+1, K_IDLE, 1, "wake_idle1");
    exp_at(b+2, K_CLK, 4'b0100, "wake_clk2"); exp_at(b+2, K_RDY, 4'b0100, "wake_rdy2");
    exp_at(b+2, K_IDLE, 0, "wake_idle2");
    exp_at(b+6, K_RDY, 4'b0100, "wake_hold_rdy"); exp_at(b+7, K_RDY, 0, "wake_off_rdy");
    exp_at(b+7, K_CLK, 4'b0100, "wake_last_clk"); exp_at(b+8, K_CLK, 0, "wake_stop_clk");
    exp_at(b+7, K_IDLE, 0, "wake_idle7"); exp_at(b+8, K_IDLE, 1, "wake_idle8");
    tick(3);
    local_en = '0;
    tick(10);

    // Hold-off on channel 0, hold_cfg changed mid-HOLD must be ignored
    b = cyc;
    local_en = 4'b0001;
    exp_at(b+2, K_RDY, 4'b0001, "hold_rdy_on");
    exp_at(b+6, K_RDY, 4'b0001, "hold_rdy_last"); exp_at(b+7, K_RDY, 0, "hold_rdy_off");
    exp_at(b+7, K_CLK, 4'b0001, "hold_clk_last"); exp_at(b+8, K_CLK, 0, "hold_clk_off");
    exp_at(b+7, K_IDLE, 0, "hold_idle7"); exp_at(b+8, K_IDLE, 1, "hold_idle8");
    tick(3);
    local_en = '0;
    tick(1);
    hold_cfg = 4'd7;
    tick(9);
    hold_cfg = 4'd5;

    // Re-request during HOLD on channel 1, then a drop reloads 5
    b = cyc;
    local_en = 4'b0010;
    for (int k = 2; k <= 13; k++) exp_at(b+k, K_RDY, 4'b0010, "rereq_rdy");
    for (int k = 2; k <= 14; k++) exp_at(b+k, K_CLK, 4'b0010, "rereq_clk");
    exp_at(b+14, K_RDY, 0, "rereq_rdy_off");
    exp_at(b+15, K_CLK, 0, "rereq_clk_off");
    tick(3);
    local_en = '0;
    tick(2);
    local_en = 4'b0010;
    tick(3);
    local_en = '0;
    tick(10);

    // Zero hold: one-cycle external request on channel 3 gives one gated pulse
    hold_cfg = '0;
    b = cyc;
    external_en = 4'b1000;
    exp_at(b+1, K_CLK, 0, "zero_clk1"); exp_at(b+2, K_CLK, 4'b1000, "zero_clk2");
    exp_at(b+3, K_CLK, 0, "zero_clk3");
    exp_at(b+2, K_RDY, 0, "zero_rdy2"); exp_at(b+3, K_RDY, 0, "zero_rdy3");
    exp_at(b+2, K_IDLE, 0, "zero_idle2"); exp_at(b+3, K_IDLE, 1, "zero_idle3");
    tick(1);
    external_en = '0;
    tick(4);

    // Global enable wakes all; module_en falls as local_en[0] rises in the same cycle
    b = cyc;
    module_en = 1'b1;
    exp_at(b+1, K_CLK, 0, "glob_clk1");
    exp_at(b+2, K_CLK, 4'hF, "glob_clk2"); exp_at(b+2, K_RDY, 4'hF, "glob_rdy2");
    exp_at(b+2, K_IDLE, 0, "glob_idle2");
    exp_at(b+4, K_RDY, 4'b0001, "glob_swap_rdy"); exp_at(b+4, K_CLK, 4'hF, "glob_swap_clk4");
    exp_at(b+5, K_CLK, 4'b0001, "glob_swap_clk5");
    exp_at(b+6, K_RDY, 0, "glob_end_rdy"); exp_at(b+6, K_CLK, 4'b0001, "glob_end_clk6");
    exp_at(b+7, K_CLK, 0, "glob_end_clk7");
    exp_at(b+6, K_IDLE, 0, "glob_idle6"); exp_at(b+7, K_IDLE, 1, "glob_idle7");
    tick(3);
    module_en = 1'b0;
    local_en  = 4'b0001;
    tick(2);
    local_en  = '0;
    tick(5);

    // Scan mode opens every clock without disturbing status
    hold_cfg = 4'd3;
    b = cyc;
    scan_en = 1'b1;
    exp_at(b, K_CLK, 0, "scan_clk0");
    for (int k = 1; k <= 3; k++) exp_at(b+k, K_CLK, 4'hF, "scan_clk");
    exp_at(b+4, K_CLK, 0, "scan_clk_off");
    exp_at(b+2, K_IDLE, 1, "scan_idle2"); exp_at(b+4, K_IDLE, 1, "scan_idle4");
    exp_at(b+2, K_RDY, 0, "scan_rdy");
    tick(3);
    scan_en = 1'b0;
    tick(3);

    // Reset mid-HOLD, then normal operation resumes
    hold_cfg = 4'd5;
    b = cyc;
    local_en = 4'b0001;
    exp_at(b+4, K_RDY, 4'b0001, "rsth_rdy4"); exp_at(b+4, K_IDLE, 0, "rsth_idle4");
    exp_at(b+5, K_RDY, 0, "rsth_rdy5"); exp_at(b+5, K_IDLE, 1, "rsth_idle5");
    exp_at(b+5, K_CLK, 4'b0001, "rsth_clk5_full_pulse");
    exp_at(b+6, K_CLK, 0, "rsth_clk6"); exp_at(b+6, K_RDY, 0, "rsth_rdy6");
    exp_at(b+7, K_CLK, 0, "rsth_clk7"); exp_at(b+7, K_IDLE, 1, "rsth_idle7");
    exp_at(b+9, K_CLK, 0, "rsth_clk9");
    exp_at(b+10, K_CLK, 4'b0001, "rsth_clk10"); exp_at(b+10, K_RDY, 4'b0001, "rsth_rdy10");
    exp_at(b+10, K_IDLE, 0, "rsth_idle10");
    exp_at(b+16, K_RDY, 4'b0001, "rsth_rdy16"); exp_at(b+17, K_RDY, 0, "rsth_rdy17");
    tick(3);
    local_en = '0;
    tick(2);
    cpurst_b = 1'b0;
    tick(2);
    cpurst_b = 1'b1;
    tick(1);
    local_en = 4'b0001;
    tick(3);
    local_en = '0;
    tick(9);

    exp_at(cyc, K_GLITCH, 0, "clk_pulse_width");
    tick(2);
    for (int i = 0; i < 10 && sb.size() > 0; i++) tick(1);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
